// File: rtl/ysyx_220066_trap_ctrl_if.sv
// Commit/CSR/redirect bundle between the pipeline commit stage and the M-mode trap controller.
// The slave side is the trap controller. timer_intr travels with the bundle from the CLINT.
interface ysyx_220066_trap_ctrl_if;
    logic        timer_intr;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [63:0] commit_npc;
    logic        commit_ecall;
    logic        commit_mret;
    logic        pipe_idle;
    logic [11:0] csr_addr;
    logic        csr_wr;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        stall_fetch;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport master (
        output timer_intr, commit_valid, commit_pc, commit_npc, commit_ecall, commit_mret,
        output pipe_idle, csr_addr, csr_wr, csr_wdata,
        input  csr_rdata, stall_fetch, redirect_valid, redirect_pc
    );

    modport slave (
        input  timer_intr, commit_valid, commit_pc, commit_npc, commit_ecall, commit_mret,
        input  pipe_idle, csr_addr, csr_wr, csr_wdata,
        output csr_rdata, stall_fetch, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_220066_trap_ctrl.sv
// Machine-mode trap/interrupt controller: owns mstatus/mie/mip/mtvec/mepc/mcause, drains before IRQs.
// Optional minstret counter at CSR 0xB02 is enabled by defining YSYX_220066_MINSTRET_EN.
module ysyx_220066_trap_ctrl #(
    parameter logic [63:0] RESET_MTVEC = 64'h8000_0000,
    parameter logic [63:0] CAUSE_TIMER = 64'h8000_0000_0000_0007,
    parameter logic [63:0] CAUSE_ECALL = 64'd11
) (
    input logic                    clk,
    input logic                    rst,
    ysyx_220066_trap_ctrl_if.slave bus
);
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    typedef enum logic [1:0] {RUN, DRAIN, REDIR} state_t;

    state_t      state;
    logic        mst_mie;
    logic        mst_mpie;
    logic        mie_mtie;
    logic        mtip_q;
    logic [63:0] mtvec;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] npc_q;
    logic        redirect_valid_q;
    logic [63:0] redirect_pc_q;

    logic irq;
    logic csr_we;
    logic do_ecall;
    logic do_mret;

    assign irq      = mtip_q & mst_mie & mie_mtie;
    assign csr_we   = bus.commit_valid & bus.csr_wr;
    assign do_ecall = bus.commit_valid & bus.commit_ecall;
    assign do_mret  = bus.commit_valid & bus.commit_mret & ~bus.commit_ecall;

    // Stall rises in the same cycle irq is seen in RUN, unless a trap commit preempts it.
    assign bus.stall_fetch    = (state != RUN) | (irq & ~(do_ecall | do_mret));
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            mst_mie          <= 1'b0;
            mst_mpie         <= 1'b0;
            mie_mtie         <= 1'b0;
            mtip_q           <= 1'b0;
            mtvec            <= RESET_MTVEC;
            mepc             <= '0;
            mcause           <= '0;
            npc_q            <= RESET_MTVEC;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mtip_q           <= bus.timer_intr;
            redirect_valid_q <= 1'b0;
            if (bus.commit_valid)
                npc_q <= bus.commit_npc;

            // CSR writes first; trap updates below override them on the same cycle.
            if (csr_we) begin
                case (bus.csr_addr)
                    CSR_MSTATUS: begin
                        mst_mie  <= bus.csr_wdata[3];
                        mst_mpie <= bus.csr_wdata[7];
                    end
                    CSR_MIE:    mie_mtie <= bus.csr_wdata[7];
                    CSR_MTVEC:  mtvec    <= {bus.csr_wdata[63:2], 2'b00};
                    CSR_MEPC:   mepc     <= {bus.csr_wdata[63:2], 2'b00};
                    CSR_MCAUSE: mcause   <= bus.csr_wdata;
                    default: ;
                endcase
            end

            case (state)
                RUN, DRAIN: begin
                    if (do_ecall) begin
                        mepc             <= bus.commit_pc;
                        mcause           <= CAUSE_ECALL;
                        mst_mpie         <= mst_mie;
                        mst_mie          <= 1'b0;
                        redirect_pc_q    <= mtvec;
                        redirect_valid_q <= 1'b1;
                        state            <= REDIR;
                    end else if (do_mret) begin
                        mst_mie          <= mst_mpie;
                        mst_mpie         <= 1'b1;
                        redirect_pc_q    <= mepc;
                        redirect_valid_q <= 1'b1;
                        state            <= REDIR;
                    end else if (state == RUN) begin
                        if (irq)
                            state <= DRAIN;
                    end else if (!irq) begin
                        state <= RUN;
                    end else if (bus.pipe_idle && !bus.commit_valid) begin
                        mepc             <= npc_q;
                        mcause           <= CAUSE_TIMER;
                        mst_mpie         <= mst_mie;
                        mst_mie          <= 1'b0;
                        redirect_pc_q    <= mtvec;
                        redirect_valid_q <= 1'b1;
                        state            <= REDIR;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef YSYX_220066_MINSTRET_EN
    logic [63:0] minstret;

    always_ff @(posedge clk) begin
        if (rst)
            minstret <= '0;
        else if (csr_we && bus.csr_addr == CSR_MINSTRET)
            minstret <= bus.csr_wdata;
        else if (bus.commit_valid)
            minstret <= minstret + 64'd1;
    end
`endif

    always_comb begin
        bus.csr_rdata = '0;
        case (bus.csr_addr)
            CSR_MSTATUS: begin
                bus.csr_rdata[3] = mst_mie;
                bus.csr_rdata[7] = mst_mpie;
            end
            CSR_MIE:      bus.csr_rdata[7] = mie_mtie;
            CSR_MTVEC:    bus.csr_rdata    = mtvec;
            CSR_MEPC:     bus.csr_rdata    = mepc;
            CSR_MCAUSE:   bus.csr_rdata    = mcause;
            CSR_MIP:      bus.csr_rdata[7] = mtip_q;
`ifdef YSYX_220066_MINSTRET_EN
            CSR_MINSTRET: bus.csr_rdata    = minstret;
`endif
            default: ;
        endcase
    end
endmodule

// File: doc/ysyx_220066_trap_ctrl.md
Name: ysyx_220066_trap_ctrl

Overview:
Machine-mode trap and interrupt controller. It sits directly downstream of the CLINT and consumes that block's level timer interrupt `intr`. It owns the mstatus, mie, mip, mtvec, mepc and mcause CSRs. It arbitrates ecall, mret and the timer interrupt at the commit point, drains the pipeline before taking an interrupt, and drives a one-cycle PC redirect to fetch.

Parameters:
RESET_MTVEC, 64'h8000_0000, reset value of mtvec (direct mode only).
CAUSE_TIMER, 64'h8000_0000_0000_0007, mcause value written for the machine timer interrupt.
CAUSE_ECALL, 64'd11, mcause value written for ecall from M-mode.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
timer_intr  in  1  level interrupt from the CLINT
commit_valid  in  1  one instruction retires this cycle
commit_pc  in  64  PC of the retiring instruction
commit_npc  in  64  architectural next PC of the retiring instruction
commit_ecall  in  1  the retiring instruction is ecall (qualified by commit_valid)
commit_mret  in  1  the retiring instruction is mret (qualified by commit_valid)
pipe_idle  in  1  no instruction is in flight behind fetch
csr_addr  in  12  CSR address, read and write
csr_wr  in  1  CSR write strobe (qualified by commit_valid)
csr_wdata  in  64  CSR write data (already merged for csrrs/csrrc)
csr_rdata  out  64  combinational CSR read data
stall_fetch  out  1  fetch must hold and issue nothing new
redirect_valid  out  1  one-cycle pulse: fetch loads redirect_pc
redirect_pc  out  64  redirect target

Behaviour:
- Reset values:
  - mstatus=0, mie=0, mepc=0, mcause=0, mtvec=RESET_MTVEC, mtip_q=0, npc_q=RESET_MTVEC.
  - State=RUN. stall_fetch=0, redirect_valid=0, redirect_pc=0.
- Registered inputs and tracking:
  - mtip_q <= timer_intr every cycle. mip.MTIP (bit 7) reads mtip_q. mip ignores writes.
  - npc_q <= commit_npc on every commit_valid.
- CSR map and field masks:
  - mstatus 0x300: only MIE (bit 3) and MPIE (bit 7) are writable. Other bits read 0.
  - mie 0x304: only MTIE (bit 7) is writable.
  - mtvec 0x305: bits [1:0] are forced to 0.
  - mepc 0x341: bits [1:0] are forced to 0.
  - mcause 0x342: full 64-bit.
  - mip 0x344: read-only.
  - Unmapped addresses read 0; writes to them are ignored.
- Interrupt pending: irq = mtip_q & mstatus.MIE & mie.MTIE.
- State RUN:
  - commit_valid & commit_ecall: mepc<=commit_pc; mcause<=CAUSE_ECALL; MPIE<=MIE; MIE<=0; redirect_pc<=mtvec; go to REDIR.
  - else commit_valid & commit_mret: MIE<=MPIE; MPIE<=1; redirect_pc<=mepc; go to REDIR.
  - else irq: go to DRAIN. stall_fetch=1 is combinational from this cycle.
- State DRAIN (stall_fetch=1):
  - In-flight instructions keep committing; npc_q keeps tracking them.
  - A commit with ecall or mret takes its RUN action, and the interrupt is abandoned.
  - If irq drops (timer re-armed, MIE/MTIE cleared by a CSR write), return to RUN and release stall.
  - Else if pipe_idle & ~commit_valid: mepc<=npc_q; mcause<=CAUSE_TIMER; MPIE<=MIE; MIE<=0; redirect_pc<=mtvec; go to REDIR.
- State REDIR:
  - redirect_valid=1 and stall_fetch=1 for exactly one cycle.
  - Then return to RUN unconditionally. irq is not re-evaluated in REDIR.
  - MIE is now 0, so no nested interrupt is taken.
- Latency:
  - ecall/mret commit to redirect_valid is 1 cycle.
  - timer_intr rising to stall_fetch is 1 cycle (via mtip_q).
  - stall to redirect is drain length + 1 cycle.
- Priority on the same cycle:
  - ecall/mret > interrupt.
  - Trap updates to mstatus/mepc/mcause override a simultaneous csr_wr to the same CSR.
  - A csr_wr to mtvec on the trap cycle is visible to the redirect only from the next trap.
- Reset mid-DRAIN or mid-REDIR: go to RUN immediately, no redirect pulse, all CSRs at reset values.

Optional Feature:
YSYX_220066_MINSTRET_EN
- Defined: 64-bit minstret counter at CSR 0xB02.
  - Reset 0; +1 per commit_valid; wraps modulo 2^64.
  - csr_wr to 0xB02 loads csr_wdata, and the write wins over the same-cycle increment.
- Undefined: 0xB02 reads 0, writes are ignored, and no counter flop exists.

Test Plan:
1. Reset, read all CSRs -> mtvec=0x8000_0000, all others 0; stall_fetch=0, redirect_valid=0.
2. Write mtvec=0x8000_0103, then commit ecall at pc 0x8000_0010 with MIE=1 -> next cycle redirect_valid=1, redirect_pc=0x8000_0100; mepc=0x8000_0010, mcause=11, MIE=0, MPIE=1.
3. Set MIE=1, MTIE=1; raise timer_intr; last commit_npc=0x8000_0044; hold pipe_idle=0 for 3 cycles then 1 -> stall_fetch from cycle+1, redirect on drain completion+1; mepc=0x8000_0044, mcause=0x8000_0000_0000_0007.
4. During DRAIN, write mie=0 -> return to RUN, stall_fetch=0, no redirect_valid, mepc unchanged.
5. Interrupt pending, and ecall commits in the same cycle -> mcause=11 and the interrupt is not taken; then mret -> redirect_pc=mepc, MIE=1, and the interrupt is taken afterwards.
6. With YSYX_220066_MINSTRET_EN, 5 commits after reset -> minstret=5. Write 0xFFFF_FFFF_FFFF_FFFF, then 1 commit -> minstret=0.
